instr_tlb: RTL and testbench

Instruction-side translation lookaside buffer between the fetch unit and the AXI master. It translates each 32-bit fetch virtual address to a physical address through a small fully associative cache of page-table entries. On a miss it performs a single-level page-table walk: one word-read request goes to the AXI master, and the returned PTE is installed. The block starts translating `virt_addr_init` by itself out of reset, so fetch needs no first request.

---
 rtl/itlb_pkg.sv | 27 ++
 rtl/instr_tlb_if.sv | 29 ++
 rtl/itlb_cam.sv | 66 ++++++
 rtl/instr_tlb.sv | 139 +++++++++++++
 tb/tb_instr_tlb.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/itlb_pkg.sv
// Shared types and constants for the instruction TLB: page geometry, the entry
// record held by the CAM, the walk FSM state encoding and the PTE address helper.
package itlb_pkg;

  localparam int PAGE_OFFSET_W = 12;
  localparam int VPN_W         = 20;
  localparam int PPN_W         = 20;

  typedef struct packed {
    logic             valid;
    logic [VPN_W-1:0] vpn;
    logic [PPN_W-1:0] ppn;
  } tlb_entry_t;

  typedef enum logic [1:0] {
    ST_RESET_WALK = 2'd0,
    ST_LOOKUP     = 2'd1,
    ST_WAIT       = 2'd2
  } itlb_state_e;

  // Single-level table: one 32-bit PTE per virtual page.
  function automatic logic [31:0] pte_addr(input logic [31:0]      base,
                                           input logic [VPN_W-1:0] vpn);
    return base + {10'b0, vpn, 2'b00};
  endfunction

endpackage

// File: rtl/instr_tlb_if.sv
// Fetch-side and AXI-master-side signals of the instruction TLB.
// The slave modport is the TLB; the master modport is its environment.
interface instr_tlb_if;

  // Handshake rule: every *_VALID is a valid-only qualifier with no ready/back-pressure.
  // The receiver samples the data on the rising edge where VALID is high. ADDR_TO_AXIM_VALID
  // is a single-cycle pulse, and PHY_ADDR_VALID stays high while the result is held.
  logic        TLB_FLUSH;
  logic [31:0] VIRT_ADDR;
  logic        VIRT_ADDR_VALID;
  logic [31:0] CURR_ADDR;
  logic        PHY_ADDR_VALID;
  logic [31:0] PHY_ADDR;
  logic        ADDR_TO_AXIM_VALID;
  logic [31:0] ADDR_TO_AXIM;
  logic        DATA_FROM_AXIM_VALID;
  logic [31:0] DATA_FROM_AXIM;

  modport slave (
    input  TLB_FLUSH, VIRT_ADDR, VIRT_ADDR_VALID, DATA_FROM_AXIM_VALID, DATA_FROM_AXIM,
    output CURR_ADDR, PHY_ADDR_VALID, PHY_ADDR, ADDR_TO_AXIM_VALID, ADDR_TO_AXIM
  );

  modport master (
    output TLB_FLUSH, VIRT_ADDR, VIRT_ADDR_VALID, DATA_FROM_AXIM_VALID, DATA_FROM_AXIM,
    input  CURR_ADDR, PHY_ADDR_VALID, PHY_ADDR, ADDR_TO_AXIM_VALID, ADDR_TO_AXIM
  );

endinterface

// File: rtl/itlb_cam.sv
// Fully associative entry store: parallel tag match on the registered contents,
// one fill port with a round-robin victim pointer, and a flush that clears everything.
module itlb_cam
  import itlb_pkg::*;
#(
  parameter int ENTRIES = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [VPN_W-1:0] lookup_vpn,
  output logic             hit,
  output logic [PPN_W-1:0] hit_ppn,
  input  logic             fill_en,
  input  logic [VPN_W-1:0] fill_vpn,
  input  logic [PPN_W-1:0] fill_ppn
);

  localparam int PTR_W = $clog2(ENTRIES);

  tlb_entry_t       entries_q [ENTRIES];
  tlb_entry_t       entries_d [ENTRIES];
  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;

  // A VPN is only filled after it missed, so at most one entry can match.
  always_comb begin
    hit     = 1'b0;
    hit_ppn = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (entries_q[i].valid && (entries_q[i].vpn == lookup_vpn)) begin
        hit     = 1'b1;
        hit_ppn = entries_q[i].ppn;
      end
    end
  end

  // Flush is applied after the fill so a coincident fill is dropped.
  always_comb begin
    entries_d = entries_q;
    ptr_d     = ptr_q;
    if (fill_en) begin
      entries_d[ptr_q] = {1'b1, fill_vpn, fill_ppn};
      ptr_d            = ptr_q + 1'b1;
    end
    if (flush) begin
      for (int i = 0; i < ENTRIES; i++) begin
        entries_d[i].valid = 1'b0;
      end
      ptr_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        entries_q[i] <= '0;
      end
      ptr_q <= '0;
    end else begin
      entries_q <= entries_d;
      ptr_q     <= ptr_d;
    end
  end

endmodule

// File: rtl/instr_tlb.sv
// Instruction TLB top: lookup/walk FSM around itlb_cam, with a self-started walk out of reset.
// Optional hit/miss counters are built when ITLB_STATS_EN is defined.
module instr_tlb
  import itlb_pkg::*;
#(
  parameter logic [31:0] virt_addr_init = 32'h0000_0000,
  parameter logic [31:0] PT_BASE        = 32'h0000_0000,
  parameter int          ENTRIES        = 8
) (
  input  logic        CLK,
  input  logic        RST,
  instr_tlb_if.slave  tlb,
`ifdef ITLB_STATS_EN
  output logic [31:0] HIT_COUNT,
  output logic [31:0] MISS_COUNT,
`endif
  output itlb_state_e DBG_STATE
);

  itlb_state_e state_q, state_d;
  logic [31:0] curr_addr_q, curr_addr_d;
  logic [31:0] phy_addr_q, phy_addr_d;
  logic        phy_valid_q, phy_valid_d;
  logic [31:0] axim_addr_q, axim_addr_d;
  logic        axim_valid_q, axim_valid_d;
`ifdef ITLB_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;
`endif

  logic             cam_hit;
  logic [PPN_W-1:0] cam_ppn;
  logic             fill_en;

  itlb_cam #(.ENTRIES(ENTRIES)) u_cam (
    .clk        (CLK),
    .rst        (RST),
    .flush      (tlb.TLB_FLUSH),
    .lookup_vpn (tlb.VIRT_ADDR[31 -: VPN_W]),
    .hit        (cam_hit),
    .hit_ppn    (cam_ppn),
    .fill_en    (fill_en),
    .fill_vpn   (curr_addr_q[31 -: VPN_W]),
    .fill_ppn   (tlb.DATA_FROM_AXIM[PPN_W-1:0])
  );

  always_comb begin
    state_d      = state_q;
    curr_addr_d  = curr_addr_q;
    phy_addr_d   = phy_addr_q;
    phy_valid_d  = phy_valid_q;
    axim_addr_d  = axim_addr_q;
    axim_valid_d = 1'b0;
    fill_en      = 1'b0;
`ifdef ITLB_STATS_EN
    hit_cnt_d    = hit_cnt_q;
    miss_cnt_d   = miss_cnt_q;
`endif
    case (state_q)
      ST_RESET_WALK: begin
        axim_addr_d  = pte_addr(PT_BASE, curr_addr_q[31 -: VPN_W]);
        axim_valid_d = 1'b1;
        phy_valid_d  = 1'b0;
        state_d      = ST_WAIT;
`ifdef ITLB_STATS_EN
        miss_cnt_d   = miss_cnt_q + 32'd1;
`endif
      end
      ST_LOOKUP: begin
        if (tlb.VIRT_ADDR_VALID) begin
          curr_addr_d = tlb.VIRT_ADDR;
          if (cam_hit) begin
            phy_addr_d  = {cam_ppn, tlb.VIRT_ADDR[PAGE_OFFSET_W-1:0]};
            phy_valid_d = 1'b1;
`ifdef ITLB_STATS_EN
            hit_cnt_d   = hit_cnt_q + 32'd1;
`endif
          end else begin
            phy_valid_d  = 1'b0;
            axim_addr_d  = pte_addr(PT_BASE, tlb.VIRT_ADDR[31 -: VPN_W]);
            axim_valid_d = 1'b1;
            state_d      = ST_WAIT;
`ifdef ITLB_STATS_EN
            miss_cnt_d   = miss_cnt_q + 32'd1;
`endif
          end
        end
      end
      ST_WAIT: begin
        // Fetch requests are ignored here; fetch re-presents once PHY_ADDR_VALID rises.
        if (tlb.DATA_FROM_AXIM_VALID) begin
          fill_en     = 1'b1;
          phy_addr_d  = {tlb.DATA_FROM_AXIM[PPN_W-1:0], curr_addr_q[PAGE_OFFSET_W-1:0]};
          phy_valid_d = 1'b1;
          state_d     = ST_LOOKUP;
        end
      end
      default: state_d = ST_RESET_WALK;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= ST_RESET_WALK;
      curr_addr_q  <= virt_addr_init;
      phy_addr_q   <= '0;
      phy_valid_q  <= 1'b0;
      axim_addr_q  <= '0;
      axim_valid_q <= 1'b0;
`ifdef ITLB_STATS_EN
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      curr_addr_q  <= curr_addr_d;
      phy_addr_q   <= phy_addr_d;
      phy_valid_q  <= phy_valid_d;
      axim_addr_q  <= axim_addr_d;
      axim_valid_q <= axim_valid_d;
`ifdef ITLB_STATS_EN
      hit_cnt_q    <= hit_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
`endif
    end
  end

  assign tlb.CURR_ADDR          = curr_addr_q;
  assign tlb.PHY_ADDR           = phy_addr_q;
  assign tlb.PHY_ADDR_VALID     = phy_valid_q;
  assign tlb.ADDR_TO_AXIM       = axim_addr_q;
  assign tlb.ADDR_TO_AXIM_VALID = axim_valid_q;
  assign DBG_STATE              = state_q;
`ifdef ITLB_STATS_EN
  assign HIT_COUNT              = hit_cnt_q;
  assign MISS_COUNT             = miss_cnt_q;
`endif

endmodule

// File: tb/tb_instr_tlb.sv
// Bench for instr_tlb with a one-cycle PTE memory returning ADDR>>2, so every PA equals its VA.
// Optional counters are checked when ITLB_STATS_EN is defined.
module tb_instr_tlb;
  import itlb_pkg::*;

  logic        clk;
  logic        rst;
  itlb_state_e dbg_state;
`ifdef ITLB_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  instr_tlb_if bus ();

  instr_tlb #(
    .virt_addr_init (32'h0000_0000),
    .PT_BASE        (32'h0000_0000),
    .ENTRIES        (8)
  ) dut (
    .CLK        (clk),
    .RST        (rst),
    .tlb        (bus),
`ifdef ITLB_STATS_EN
    .HIT_COUNT  (hit_count),
    .MISS_COUNT (miss_count),
`endif
    .DBG_STATE  (dbg_state)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [63:0] exp_q[$];  // {CURR_ADDR, PHY_ADDR}

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  // PTE memory: data one cycle after each request
  initial begin
    logic        pend;
    logic [31:0] pend_addr;
    pend                     = 1'b0;
    pend_addr                = '0;
    bus.DATA_FROM_AXIM_VALID = 1'b0;
    bus.DATA_FROM_AXIM       = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.DATA_FROM_AXIM_VALID = pend;
      bus.DATA_FROM_AXIM       = pend ? (pend_addr >> 2) : 32'hFFFF_FFFF;
      pend                     = bus.ADDR_TO_AXIM_VALID;
      pend_addr                = bus.ADDR_TO_AXIM;
    end
  end

  task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic pop_check(input string tag);
    logic [63:0] e;
    if (exp_q.size() == 0) begin
      check32({tag, "_sb_nonempty"}, 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      check32({tag, "_curr"}, bus.CURR_ADDR, e[63:32]);
      check32({tag, "_phy"}, bus.PHY_ADDR, e[31:0]);
    end
  endtask

  task automatic wait_result(output int cyc);
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (!bus.PHY_ADDR_VALID && cyc < 20);
  endtask

  // Called #1 after an edge that sampled RST high; releases reset and follows the walk of VA 0.
  task automatic reset_walk_check(input string tag);
    int cyc;
    check32({tag, "_rst_curr"}, bus.CURR_ADDR, 32'h0);
    check32({tag, "_rst_phy"}, bus.PHY_ADDR, 32'h0);
    check32({tag, "_rst_phy_valid"}, 32'(bus.PHY_ADDR_VALID), 32'd0);
    check32({tag, "_rst_req_valid"}, 32'(bus.ADDR_TO_AXIM_VALID), 32'd0);
    check32({tag, "_rst_req_addr"}, bus.ADDR_TO_AXIM, 32'h0);
    check32({tag, "_rst_state"}, 32'(dbg_state), 32'(ST_RESET_WALK));
    rst = 1'b0;
    exp_q.push_back({32'h0, 32'h0});
    @(posedge clk);
    #1;
    check32({tag, "_walk_req_valid"}, 32'(bus.ADDR_TO_AXIM_VALID), 32'd1);
    check32({tag, "_walk_req_addr"}, bus.ADDR_TO_AXIM, 32'h0);
    check32({tag, "_walk_phy_valid"}, 32'(bus.PHY_ADDR_VALID), 32'd0);
    wait_result(cyc);
    check32({tag, "_walk_latency"}, 32'(cyc + 1), 32'd3);
    pop_check(tag);
  endtask

  // Present one VA for a single cycle and follow it to its result.
  task automatic translate(input logic [31:0] va, input bit exp_hit, input bit flush_in_wait);
    int cyc;
    bus.VIRT_ADDR       = va;
    bus.VIRT_ADDR_VALID = 1'b1;
    exp_q.push_back({va, va});
    @(posedge clk);
    #1;
    bus.VIRT_ADDR_VALID = 1'b0;
    if (exp_hit) begin
      check32("hit_phy_valid", 32'(bus.PHY_ADDR_VALID), 32'd1);
      check32("hit_req_valid", 32'(bus.ADDR_TO_AXIM_VALID), 32'd0);
      pop_check("hit");
    end else begin
      check32("miss_phy_valid", 32'(bus.PHY_ADDR_VALID), 32'd0);
      check32("miss_req_valid", 32'(bus.ADDR_TO_AXIM_VALID), 32'd1);
      check32("miss_req_addr", bus.ADDR_TO_AXIM, {10'b0, va[31:12], 2'b00});
      // junk fetch request while walking must be ignored
      bus.VIRT_ADDR       = 32'hABCD_E123;
      bus.VIRT_ADDR_VALID = 1'b1;
      bus.TLB_FLUSH       = flush_in_wait;
      wait_result(cyc);
      bus.VIRT_ADDR_VALID = 1'b0;
      bus.TLB_FLUSH       = 1'b0;
      check32("miss_latency", 32'(cyc + 1), 32'd3);
      pop_check("miss");
    end
  endtask

  // Back-to-back hits, one new VA every cycle.
  task automatic stream_hits(input logic [31:0] start, input int n);
    logic [31:0] va;
    for (int i = 0; i < n; i++) begin
      va                  = start + 32'(4 * i);
      bus.VIRT_ADDR       = va;
      bus.VIRT_ADDR_VALID = 1'b1;
      exp_q.push_back({va, va});
      @(posedge clk);
      #1;
      check32("seq_phy_valid", 32'(bus.PHY_ADDR_VALID), 32'd1);
      check32("seq_req_valid", 32'(bus.ADDR_TO_AXIM_VALID), 32'd0);
      pop_check("seq");
    end
    bus.VIRT_ADDR_VALID = 1'b0;
  endtask

  task automatic flush_pulse();
    bus.TLB_FLUSH = 1'b1;
    @(posedge clk);
    #1;
    bus.TLB_FLUSH = 1'b0;
  endtask

  initial begin
    rst                 = 1'b1;
    bus.TLB_FLUSH       = 1'b0;
    bus.VIRT_ADDR       = '0;
    bus.VIRT_ADDR_VALID = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_walk_check("reset");

    stream_hits(32'h0000_0004, 5);
`ifdef ITLB_STATS_EN
    check32("stats_hit_count", hit_count, 32'd5);
    check32("stats_miss_count", miss_count, 32'd1);
`endif
    stream_hits(32'h0000_0018, 1018);

    translate(32'h1001_0000, 1'b0, 1'b0);
    translate(32'h1001_0ABC, 1'b1, 1'b0);

    for (int p = 0; p < 9; p++) begin
      translate(32'h0100_0000 + 32'(p * 32'h1000), 1'b0, 1'b0);
    end
    translate(32'h0100_0020, 1'b0, 1'b0);
    translate(32'h0100_8030, 1'b1, 1'b0);

    flush_pulse();
    translate(32'h0000_0010, 1'b0, 1'b0);
    translate(32'h0000_0014, 1'b1, 1'b0);
    translate(32'h0000_5000, 1'b0, 1'b1);
    translate(32'h0000_5004, 1'b0, 1'b0);
    translate(32'h0000_0018, 1'b0, 1'b0);

    // reset mid-walk; the stale response lands in the first cycle after reset
    bus.VIRT_ADDR       = 32'h0000_7000;
    bus.VIRT_ADDR_VALID = 1'b1;
    @(posedge clk);
    #1;
    bus.VIRT_ADDR_VALID = 1'b0;
    check32("midwalk_req_valid", 32'(bus.ADDR_TO_AXIM_VALID), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    reset_walk_check("midwalk");

    check32("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
